// File: rtl/noc_pkg.sv
// noc_pkg: shared routing command encodings and dummy-data value for NoC switch blocks.
package noc_pkg;
    typedef enum logic [1:0] {
        CMD_DROP = 2'b00,
        CMD_LOW  = 2'b01,
        CMD_HIGH = 2'b10,
        CMD_BOTH = 2'b11
    } cmd_e;

    localparam logic DUMMY_BIT = 1'b0;
endpackage

// File: rtl/noc_fifo_lite.sv
// noc_fifo_lite: single-clock FIFO with async active-high reset; head reads as dummy data when empty.
module noc_fifo_lite
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head  = o_empty ? {DATA_WIDTH{DUMMY_BIT}} : r_mem[r_rd_ptr];
endmodule

// File: rtl/distribute_1x2_seq.sv
// distribute_1x2_seq: 1-to-2 distribute switch with per-branch FIFOs (drop/low/high/multicast).
// Optional macro DISTRIBUTE_1X2_DROP_CNT_EN adds a saturating o_drop_cnt of accepted cmd-00 words.
module distribute_1x2_seq
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_data_bus,
    output logic                      o_ready,
    input  logic [COMMMAND_WIDTH-1:0] i_cmd,
    input  logic                      i_en,
    output logic [1:0]                o_valid,
    output logic [2*DATA_WIDTH-1:0]   o_data_bus,
`ifdef DISTRIBUTE_1X2_DROP_CNT_EN
    output logic [15:0]               o_drop_cnt,
`endif
    input  logic [1:0]                i_ready
);
    logic [1:0] w_tgt;
    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic       w_accept;

    assign w_tgt    = i_cmd[1:0];
    // Full is taken before same-cycle pops, so a full target always stalls the word.
    assign o_ready  = i_en & ~|(w_tgt & w_full);
    assign w_accept = i_valid & o_ready;
    assign w_push   = {2{w_accept}} & w_tgt;
    assign w_pop    = ~w_empty & i_ready & {2{i_en}};
    assign o_valid  = ~w_empty;

    for (genvar g = 0; g < 2; g++) begin : g_branch
        noc_fifo_lite #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .i_push (w_push[g]),
            .i_pop  (w_pop[g]),
            .i_data (i_data_bus),
            .o_full (w_full[g]),
            .o_empty(w_empty[g]),
            .o_head (o_data_bus[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef DISTRIBUTE_1X2_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_accept & (cmd_e'(w_tgt) == CMD_DROP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_distribute_1x2_seq.sv
// tb_distribute_1x2_seq: directed plus random stimulus checked against a queue-based model of the switch.
module tb_distribute_1x2_seq;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic          o_ready;
    logic [CW-1:0] i_cmd;
    logic          i_en;
    logic [1:0]    o_valid;
    logic [2*DW-1:0] o_data_bus;
    logic [1:0]    i_ready;
`ifdef DISTRIBUTE_1X2_DROP_CNT_EN
    logic [15:0]   o_drop_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_drop    = 0;
    logic [DW-1:0] q[2][$];

    always #5 clk = ~clk;

    distribute_1x2_seq #(
        .DATA_WIDTH    (DW),
        .COMMMAND_WIDTH(CW),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_data_bus(i_data_bus),
        .o_ready   (o_ready),
        .i_cmd     (i_cmd),
        .i_en      (i_en),
        .o_valid   (o_valid),
        .o_data_bus(o_data_bus),
`ifdef DISTRIBUTE_1X2_DROP_CNT_EN
        .o_drop_cnt(o_drop_cnt),
`endif
        .i_ready   (i_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("o_valid", 64'(o_valid), 64'({q[1].size() != 0, q[0].size() != 0}));
        chk("data_lo", 64'(o_data_bus[DW-1:0]), 64'(q[0].size() != 0 ? q[0][0] : '0));
        chk("data_hi", 64'(o_data_bus[2*DW-1:DW]), 64'(q[1].size() != 0 ? q[1][0] : '0));
`ifdef DISTRIBUTE_1X2_DROP_CNT_EN
        chk("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
`endif
    endtask

    // One cycle from a negedge: drive, check against model, apply model update, advance to next negedge.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic en, input logic [1:0] r);
        logic rdy;
        i_valid = v; i_cmd = c; i_data_bus = d; i_en = en; i_ready = r;
        #1;
        rdy = en && !((c[0] && q[0].size() == D) || (c[1] && q[1].size() == D));
        chk("o_ready", 64'(o_ready), 64'(rdy));
        chk_outputs();
        for (int b = 0; b < 2; b++)
            if (q[b].size() != 0 && r[b] && en) void'(q[b].pop_front());
        if (v && rdy) begin
            for (int b = 0; b < 2; b++)
                if (c[b]) q[b].push_back(d);
            if (c[1:0] == 2'b00 && exp_drop < 65535) exp_drop++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] r);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, r);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_cmd = '0; i_data_bus = '0; i_en = 1'b1; i_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_outputs();
        rst = 1'b0;
        @(negedge clk);

        // single low-branch word, passes through in one cycle
        step(1'b1, 2'b01, 32'hAAAAAAAA, 1'b1, 2'b11);
        idle(2, 2'b11);

        // multicast fill to 2/2 then stall
        step(1'b1, 2'b11, 32'hBBBBBBBB, 1'b1, 2'b00);
        step(1'b1, 2'b11, 32'hCCCCCCCC, 1'b1, 2'b00);
        step(1'b1, 2'b11, 32'hDDDDDDDD, 1'b1, 2'b00);
        idle(3, 2'b11);

        // full high FIFO blocks multicast atomically; low-only still accepted
        step(1'b1, 2'b10, 32'h00000011, 1'b1, 2'b00);
        step(1'b1, 2'b10, 32'h00000022, 1'b1, 2'b00);
        step(1'b1, 2'b11, 32'h00000033, 1'b1, 2'b00);
        step(1'b1, 2'b01, 32'h00000044, 1'b1, 2'b00);
        idle(4, 2'b11);

        // ordered stream on the high branch
        step(1'b1, 2'b10, 32'h1, 1'b1, 2'b10);
        step(1'b1, 2'b10, 32'h2, 1'b1, 2'b10);
        step(1'b1, 2'b10, 32'h3, 1'b1, 2'b10);
        idle(3, 2'b10);

        // freeze holds the output, then release pops
        step(1'b1, 2'b01, 32'hAAAAAAAA, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 32'h55555555, 1'b0, 2'b01);
        idle(2, 2'b01);

        // asynchronous reset mid-stream discards buffered words
        step(1'b1, 2'b11, 32'h12345678, 1'b1, 2'b00);
        step(1'b1, 2'b01, 32'h9ABCDEF0, 1'b1, 2'b00);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        q[0].delete(); q[1].delete(); exp_drop = 0;
        chk_outputs();
        @(negedge clk);
        rst = 1'b0;

        // drops are accepted and never appear on either branch
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'hDEAD0000 + i, 1'b1, 2'b11);
        chk_outputs();

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), CW'($urandom_range(0, 3)), DW'($urandom),
                 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
        idle(4, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
